// File: rtl/unidade_exibe_sequencia.sv
// unidade_exibe_sequencia
//
// Plays the stored Genius colour sequence back on the LEDs before each round.
// RAM entries 0..rodada are read one at a time. Each entry takes one cycle to
// load, is lit for T_ACESO cycles, and is followed by T_APAGADO dark cycles.
// A done pulse is issued at the end of playback.
//
// Ports:
//   clock             system clock, rising edge
//   reset             synchronous, active-high
//   iniciar_exibicao  start pulse, accepted only while idle
//   cancelar          abort playback, back to idle without a done pulse
//   rodada            index of the last entry to show, latched on start
//   mem_dado          RAM read data (one-hot colour)
//   mem_endereco      RAM read address
//   leds              colour LEDs
//   exibindo          high whenever not idle
//   fim_exibicao      one-cycle done pulse
//   db_estado         debug state code

module unidade_exibe_sequencia #(
   parameter int unsigned T_ACESO   = 1000,
   parameter int unsigned T_APAGADO = 500,
   parameter int unsigned W_END     = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             iniciar_exibicao,
   input  logic             cancelar,
   input  logic [W_END-1:0] rodada,
   input  logic [3:0]       mem_dado,
   output logic [W_END-1:0] mem_endereco,
   output logic [3:0]       leds,
   output logic             exibindo,
   output logic             fim_exibicao,
   output logic [3:0]       db_estado
);

   localparam int unsigned T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
   // Keep at least one bit so a 1-cycle on/off time still has a legal vector.
   localparam int unsigned W_TMR = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [W_TMR-1:0] ULTIMO_ACESO   = W_TMR'(T_ACESO - 1);
   localparam logic [W_TMR-1:0] ULTIMO_APAGADO = W_TMR'(T_APAGADO - 1);

   // Encodings double as the debug state code.
   typedef enum logic [3:0] {
      Ocioso  = 4'h0,
      Carrega = 4'h1,
      Aceso   = 4'h2,
      Apagado = 4'h3,
      Fim     = 4'hF
   } estadoT;

   estadoT             estadoReg, estadoNext;
   logic [W_END-1:0]   enderecoReg, enderecoNext;
   logic [W_END-1:0]   rodadaReg, rodadaNext;
   logic [3:0]         dadoReg, dadoNext;
   logic [W_TMR-1:0]   timerReg, timerNext;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         estadoReg   <= Ocioso;
         enderecoReg <= '0;
         rodadaReg   <= '0;
         dadoReg     <= '0;
         timerReg    <= '0;
      end else begin
         estadoReg   <= estadoNext;
         enderecoReg <= enderecoNext;
         rodadaReg   <= rodadaNext;
         dadoReg     <= dadoNext;
         timerReg    <= timerNext;
      end
   end

   // Next-state logic
   always_comb begin
      estadoNext   = estadoReg;
      enderecoNext = enderecoReg;
      rodadaNext   = rodadaReg;
      dadoNext     = dadoReg;
      timerNext    = timerReg;

      unique case (estadoReg)
         Ocioso: begin
            if (iniciar_exibicao && !cancelar) begin
               rodadaNext   = rodada;
               enderecoNext = '0;
               timerNext    = '0;
               estadoNext   = Carrega;
            end
         end
         Carrega: begin
            dadoNext   = mem_dado;
            timerNext  = '0;
            estadoNext = Aceso;
         end
         Aceso: begin
            if (timerReg == ULTIMO_ACESO) begin
               timerNext  = '0;
               estadoNext = Apagado;
            end else begin
               timerNext = timerReg + W_TMR'(1);
            end
         end
         Apagado: begin
            if (timerReg == ULTIMO_APAGADO) begin
               timerNext = '0;
               // End test precedes the increment so the address never wraps.
               if (enderecoReg == rodadaReg) begin
                  estadoNext = Fim;
               end else begin
                  enderecoNext = enderecoReg + W_END'(1);
                  estadoNext   = Carrega;
               end
            end else begin
               timerNext = timerReg + W_TMR'(1);
            end
         end
         Fim: begin
            estadoNext = Ocioso;
         end
         default: begin
            estadoNext = Ocioso;
         end
      endcase

      // Abort overrides everything except reset; idle is left untouched.
      if (cancelar && (estadoReg != Ocioso)) begin
         estadoNext   = Ocioso;
         enderecoNext = '0;
         timerNext    = '0;
      end
   end

   // Moore outputs
   always_comb begin
      leds         = '0;
      exibindo     = 1'b1;
      fim_exibicao = 1'b0;
      db_estado    = estadoReg;

      case (estadoReg)
         Ocioso:  exibindo     = 1'b0;
         Aceso:   leds         = dadoReg;
         Fim:     fim_exibicao = 1'b1;
         default: ;
      endcase
   end

   assign mem_endereco = enderecoReg;

endmodule

// File: tb/tb_unidade_exibe_sequencia.sv
// tb_unidade_exibe_sequencia
//
// Bench for unidade_exibe_sequencia with T_ACESO=4, T_APAGADO=2 and a RAM
// model holding 1,2,4,8,... Expected lit entries and done pulses are queued
// when a start is driven; a monitor reconstructs the same events from the
// DUT outputs and compares them in order.

module tb_unidade_exibe_sequencia;

   localparam int TA      = 4;
   localparam int TP      = 2;
   localparam int PERIODO = 1 + TA + TP;

   localparam int EV_LIT = 1;
   localparam int EV_FIM = 2;

   logic       clock;
   logic       reset;
   logic       iniciar_exibicao;
   logic       cancelar;
   logic [3:0] rodada;
   logic [3:0] mem_dado;
   logic [3:0] mem_endereco;
   logic [3:0] leds;
   logic       exibindo;
   logic       fim_exibicao;
   logic [3:0] db_estado;

   typedef struct {
      int tipo;
      int valor;
      int rel;
      int dur;
   } eventoT;

   eventoT fila[$];

   int nAssert  = 0;
   int nFalhas  = 0;
   int ciclo    = 0;
   int startCiclo = 0;
   bit ignorarEvt;

   unidade_exibe_sequencia #(
      .T_ACESO   (TA),
      .T_APAGADO (TP),
      .W_END     (4)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .iniciar_exibicao (iniciar_exibicao),
      .cancelar         (cancelar),
      .rodada           (rodada),
      .mem_dado         (mem_dado),
      .mem_endereco     (mem_endereco),
      .leds             (leds),
      .exibindo         (exibindo),
      .fim_exibicao     (fim_exibicao),
      .db_estado        (db_estado)
   );

   // RAM model: entry n holds one-hot colour 1 << (n % 4)
   assign mem_dado = 4'b0001 << mem_endereco[1:0];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) ciclo <= ciclo + 1;

   task automatic verifica(input string tag, input int obtido, input int esperado);
      nAssert++;
      if (obtido != esperado) begin
         nFalhas++;
         $display("FAIL %s: obtido %0d, esperado %0d (ciclo %0d)", tag, obtido, esperado,
                  ciclo);
      end
   endtask

   task automatic registra(input int tipo, input int valor, input int rel, input int dur);
      eventoT e;
      if (fila.size() == 0) begin
         verifica("evento_inesperado", tipo, 0);
      end else begin
         e = fila.pop_front();
         verifica("evento_tipo", tipo, e.tipo);
         verifica("evento_valor", valor, e.valor);
         verifica("evento_ciclo", rel, e.rel);
         verifica("evento_duracao", dur, e.dur);
      end
   endtask

   // Monitor: turns LED bursts and done pulses into events
   bit         emLit = 1'b0;
   int         litIni;
   logic [3:0] litVal;
   logic [3:0] litEnd;

   always @(negedge clock) begin
      if (ignorarEvt || reset) begin
         emLit = 1'b0;
      end else begin
         if (!emLit && leds != 4'b0) begin
            emLit  = 1'b1;
            litIni = ciclo;
            litVal = leds;
            litEnd = mem_endereco;
         end else if (emLit && leds == 4'b0) begin
            emLit = 1'b0;
            registra(EV_LIT, int'(litEnd) * 16 + int'(litVal), litIni - startCiclo,
                     ciclo - litIni);
         end
         if (fim_exibicao) registra(EV_FIM, 0, ciclo - startCiclo, 0);
      end
   end

   task automatic proximo();
      @(posedge clock);
      #1;
   endtask

   task automatic espera(input int n);
      repeat (n) proximo();
   endtask

   // Drives a one-cycle start and queues the playback it should produce.
   task automatic iniciar(input int r);
      startCiclo = ciclo;
      for (int i = 0; i <= r; i++) begin
         fila.push_back('{EV_LIT, i * 16 + (1 << (i % 4)), 2 + PERIODO * i, TA});
      end
      fila.push_back('{EV_FIM, 0, (r + 1) * PERIODO + 1, 0});
      rodada           = 4'(r);
      iniciar_exibicao = 1'b1;
      proximo();
      iniciar_exibicao = 1'b0;
   endtask

   task automatic aguarda(input string tag, input int limite);
      for (int i = 0; i < limite && fila.size() != 0; i++) @(negedge clock);
      verifica(tag, fila.size(), 0);
      proximo();
   endtask

   task automatic verificaOcioso(input string tag);
      @(negedge clock);
      verifica({tag, "_leds"}, leds, 0);
      verifica({tag, "_exibindo"}, exibindo, 0);
      verifica({tag, "_estado"}, db_estado, 0);
      verifica({tag, "_fim"}, fim_exibicao, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulacao nao terminou");
      $fatal(1, "watchdog");
   end

   int dbEsperado[8] = '{1, 2, 2, 2, 2, 3, 3, 15};

   initial begin
      reset            = 1'b1;
      iniciar_exibicao = 1'b0;
      cancelar         = 1'b0;
      rodada           = 4'd0;
      ignorarEvt       = 1'b1;
      espera(2);
      verificaOcioso("reset");
      verifica("reset_endereco", mem_endereco, 0);
      proximo();
      reset      = 1'b0;
      ignorarEvt = 1'b0;
      espera(2);

      // Single entry, with the state sequence traced cycle by cycle
      iniciar(0);
      for (int r = 1; r <= 8; r++) begin
         @(negedge clock);
         verifica("estado_r0", db_estado, dbEsperado[r-1]);
         verifica("endereco_r0", mem_endereco, 0);
      end
      aguarda("fila_r0", 20);
      espera(3);

      // Four entries, exibindo window checked every cycle
      iniciar(3);
      for (int r = 1; r <= 30; r++) begin
         @(negedge clock);
         verifica("exibindo_r3", exibindo, (r <= 29) ? 1 : 0);
      end
      aguarda("fila_r3", 10);
      espera(3);

      // Start re-pulsed during ACESO with a different rodada: ignored
      iniciar(2);
      espera(2);
      rodada           = 4'd1;
      iniciar_exibicao = 1'b1;
      proximo();
      iniciar_exibicao = 1'b0;
      aguarda("fila_repulso", 60);
      espera(10);

      // Abort during the second dark gap
      iniciar(3);
      espera(12);
      cancelar = 1'b1;
      proximo();
      cancelar = 1'b0;
      verificaOcioso("cancela");
      verifica("cancela_endereco", mem_endereco, 0);
      verifica("cancela_pendentes", fila.size(), 3);
      fila.delete();
      proximo();
      espera(40);
      iniciar(1);
      aguarda("fila_pos_cancela", 40);
      espera(3);

      // Cancel and start together while idle: stays idle
      rodada           = 4'd5;
      cancelar         = 1'b1;
      iniciar_exibicao = 1'b1;
      proximo();
      cancelar         = 1'b0;
      iniciar_exibicao = 1'b0;
      verificaOcioso("cancela_e_inicia");
      proximo();
      espera(10);

      // Full table: no address wrap
      iniciar(15);
      aguarda("fila_r15", 200);
      verifica("endereco_final_r15", mem_endereco, 15);
      verifica("estado_final_r15", db_estado, 0);
      espera(3);

      // Reset held for two cycles mid-ACESO
      iniciar(2);
      espera(2);
      ignorarEvt = 1'b1;
      reset      = 1'b1;
      espera(2);
      reset = 1'b0;
      verificaOcioso("reset_meio");
      verifica("reset_meio_endereco", mem_endereco, 0);
      fila.delete();
      proximo();
      ignorarEvt = 1'b0;
      espera(30);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFalhas);
      $finish;
   end

endmodule
